lcm_from_gcd: RTL and testbench

Downstream post-processing stage for the GCD unit. Captures the signed operand pair and the GCD result when the GCD unit's ready signal rises, then computes the least common multiple as |x|·|y| / gcd. The multiply is a sequential shift-add; the divide is a restoring division. The result is presented on a valid/ack output handshake and held until consumed. The block also flags dropped requests and a non-zero division remainder, which indicates a wrong GCD input.

---
 rtl/gcd_pkg.sv | 11 +
 rtl/seq_udiv.sv | 65 ++++++
 rtl/lcm_from_gcd.sv | 133 +++++++++++++
 tb/tb_lcm_from_gcd.sv | 137 +++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD unit and its LCM post-processing stage.
package gcd_pkg;

    localparam int unsigned GcdNBits = 2;
    localparam int unsigned GcdWBits = 2 * GcdNBits;

    typedef enum logic [1:0] {GCD_IDLE, GCD_RUN, GCD_DONE} gcd_state_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} lcm_state_t;

endpackage

// File: rtl/seq_udiv.sv
// Sequential restoring unsigned divider: W iterations, MSB first, done pulses once at the end.
module seq_udiv #(
    parameter int unsigned W = gcd_pkg::GcdWBits
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CntW = $clog2(W) + 1;

    logic [W-1:0]    dvd_q, rem_q, dsr_q;
    logic [CntW-1:0] cnt_q;
    logic            run_q, done_q;

    logic [W:0]   rem_sh;
    logic [W-1:0] rem_sub;
    logic         ge;

    // Remainder stays below the divisor, so the W-bit wrapped subtraction is exact.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[W-1]};
        ge      = rem_sh >= {1'b0, dsr_q};
        rem_sub = rem_sh[W-1:0] - dsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                dvd_q <= dividend;
                dsr_q <= divisor;
                rem_q <= '0;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                // Quotient bits shift into the vacated dividend LSBs.
                dvd_q <= {dvd_q[W-2:0], ge};
                rem_q <= ge ? rem_sub : rem_sh[W-1:0];
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CntW'(W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done      = done_q;
    assign quotient  = dvd_q;
    assign remainder = rem_q;

endmodule

// File: rtl/lcm_from_gcd.sv
// LCM stage: captures operands and GCD on gcd_rdy rising edge, computes |x|*|y|/gcd.
module lcm_from_gcd
    import gcd_pkg::*;
#(
    parameter int unsigned NBits = GcdNBits
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NBits-1:0]   xi,
    input  logic [NBits-1:0]   yi,
    input  logic [NBits-1:0]   gcd_xo,
    input  logic               gcd_rdy,
    output logic [2*NBits-1:0] lcm,
    output logic               lcm_valid,
    input  logic               lcm_ack,
    output logic               busy,
    output logic               drop,
    output logic               rem_err
);

    localparam int unsigned W    = 2 * NBits;
    localparam int unsigned CntW = $clog2(NBits) + 1;
    localparam logic [NBits-1:0] One = NBits'(1);

    lcm_state_t state_q, state_d;

    logic             rdy_q;
    logic [NBits-1:0] ax_q, ay_q, g_q;
    logic [W-1:0]     prod_q, lcm_q;
    logic [CntW-1:0]  cnt_q;
    logic             lcm_valid_q, drop_q, rem_err_q;

    logic             req;
    logic [NBits-1:0] abs_x, abs_y;
    logic             zero_in, last_mul, div_start, div_done;
    logic [W-1:0]     prod_add, div_q, div_r;

    always_comb begin
        req       = gcd_rdy & ~rdy_q;
        abs_x     = xi[NBits-1] ? (~xi + One) : xi;
        abs_y     = yi[NBits-1] ? (~yi + One) : yi;
        zero_in   = (gcd_xo == '0) || (abs_x == '0) || (abs_y == '0);
        last_mul  = cnt_q == CntW'(NBits - 1);
        prod_add  = ay_q[0] ? prod_q + ({{NBits{1'b0}}, ax_q} << cnt_q) : prod_q;
        div_start = (state_q == MUL) && last_mul;
    end

    seq_udiv #(
        .W (W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (prod_add),
        .divisor   ({{NBits{1'b0}}, g_q}),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = zero_in ? DONE : MUL;
            MUL:     if (last_mul) state_d = DIV;
            DIV:     if (div_done) state_d = DONE;
            DONE:    if (lcm_valid_q && lcm_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        lcm       = lcm_q;
        lcm_valid = lcm_valid_q;
        drop      = drop_q;
        rem_err   = rem_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            ax_q        <= '0;
            ay_q        <= '0;
            g_q         <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            lcm_q       <= '0;
            lcm_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            rem_err_q   <= 1'b0;
        end else begin
            rdy_q <= gcd_rdy;
            if (req && state_q != IDLE) drop_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        ax_q   <= abs_x;
                        ay_q   <= abs_y;
                        g_q    <= gcd_xo;
                        prod_q <= '0;
                        cnt_q  <= '0;
                        if (zero_in) lcm_q <= '0;
                    end
                end
                MUL: begin
                    prod_q <= prod_add;
                    ay_q   <= ay_q >> 1;
                    cnt_q  <= cnt_q + 1'b1;
                end
                DIV: begin
                    if (div_done) begin
                        lcm_q       <= div_q;
                        lcm_valid_q <= 1'b1;
                        rem_err_q   <= rem_err_q | (div_r != '0);
                    end
                end
                DONE: begin
                    // Zero path enters DONE with valid still low; raise it one cycle later.
                    if (!lcm_valid_q)  lcm_valid_q <= 1'b1;
                    else if (lcm_ack)  lcm_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Scoreboard bench for lcm_from_gcd at NBits=8.
module tb_lcm_from_gcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  xi = '0, yi = '0, gcd_xo = '0;
    logic        gcd_rdy = 1'b0;
    logic        lcm_ack = 1'b0;
    logic [15:0] lcm;
    logic        lcm_valid, busy, drop, rem_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    lcm_from_gcd #(
        .NBits (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .xi        (xi),
        .yi        (yi),
        .gcd_xo    (gcd_xo),
        .gcd_rdy   (gcd_rdy),
        .lcm       (lcm),
        .lcm_valid (lcm_valid),
        .lcm_ack   (lcm_ack),
        .busy      (busy),
        .drop      (drop),
        .rem_err   (rem_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // hold: cycles gcd_rdy stays high; stall: cycles ack is withheld;
    // inject_at: cycle of a second gcd_rdy pulse while busy (-1 = none).
    task automatic run_req(input int x, input int y, input int g, input int exp_lcm,
                           input int exp_lat, input int hold, input int stall,
                           input int inject_at);
        int lat;
        logic [15:0] exp_v;
        @(negedge clk);
        xi = 8'(x); yi = 8'(y); gcd_xo = 8'(g); gcd_rdy = 1'b1;
        exp_q.push_back(16'(exp_lcm));
        lat = 0;
        @(negedge clk);
        if (hold == 0) gcd_rdy = 1'b0;
        while (!lcm_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (hold > 0 && lat == hold) gcd_rdy = 1'b0;
            if (inject_at >= 0 && lat == inject_at) begin
                xi = 8'd1; yi = 8'd1; gcd_xo = 8'd1; gcd_rdy = 1'b1;
            end
            if (inject_at >= 0 && lat == inject_at + 1) gcd_rdy = 1'b0;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        exp_v = exp_q.pop_front();
        check_eq("lcm", 32'(lcm), 32'(exp_v));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(lcm_valid), 32'd1);
            check_eq("stall_lcm", 32'(lcm), 32'(exp_v));
        end
        lcm_ack = 1'b1;
        @(negedge clk);
        lcm_ack = 1'b0;
        check_eq("ack_valid", 32'(lcm_valid), 32'd0);
        check_eq("ack_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_lcm", 32'(lcm), 32'd0);
        check_eq("rst_valid", 32'(lcm_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_drop", 32'(drop), 32'd0);
        check_eq("rst_rem_err", 32'(rem_err), 32'd0);
        rst = 1'b0;

        run_req(12, 18, 6, 36, 25, 0, 0, -1);
        check_eq("rem_err_clean", 32'(rem_err), 32'd0);
        run_req(-4, 6, 2, 12, 25, 0, 0, -1);
        run_req(-128, -128, 128, 128, 25, 0, 0, -1);
        run_req(127, 126, 1, 16002, 25, 0, 0, -1);
        run_req(0, 5, 0, 0, 1, 0, 0, -1);

        // Level held high counts once; no second result, no drop.
        run_req(3, 4, 1, 12, 25, 10, 0, -1);
        repeat (30) @(negedge clk);
        check_eq("hold_one_result", 32'(lcm_valid), 32'd0);
        check_eq("hold_no_drop", 32'(drop), 32'd0);

        run_req(6, 10, 2, 30, 25, 0, 20, -1);

        run_req(12, 18, 6, 36, 25, 0, 0, 3);
        check_eq("drop_set", 32'(drop), 32'd1);
        repeat (30) @(negedge clk);
        check_eq("drop_no_extra", 32'(lcm_valid), 32'd0);

        run_req(12, 18, 5, 43, 25, 0, 0, -1);
        check_eq("rem_err_set", 32'(rem_err), 32'd1);
        run_req(12, 18, 6, 36, 25, 0, 0, -1);
        check_eq("rem_err_sticky", 32'(rem_err), 32'd1);

        // Asynchronous reset while dividing.
        @(negedge clk);
        xi = 8'd12; yi = 8'd18; gcd_xo = 8'd6; gcd_rdy = 1'b1;
        @(negedge clk);
        gcd_rdy = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_lcm", 32'(lcm), 32'd0);
        check_eq("arst_valid", 32'(lcm_valid), 32'd0);
        check_eq("arst_drop", 32'(drop), 32'd0);
        check_eq("arst_rem_err", 32'(rem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_req(12, 18, 6, 36, 25, 0, 0, -1);
        check_eq("post_rst_rem_err", 32'(rem_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
